// File: rtl/fifo_share_pkg.sv
// Shared types and defaults for the FIFO sharing controller.
// Optional statistics are enabled with `FIFO_SHARE_STATS_EN (see fifo_share_ctrl).
package fifo_share_pkg;

    localparam int FS_WIDTH = 8;
    localparam int FS_DEPTH = 32;
    localparam int FS_CNT_W = $clog2(FS_DEPTH + 1);

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/fifo_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter; the search starts one past rr_ptr.
// The pointer register is owned by the instantiating controller.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic             en,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] win_idx
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Scan requesters from rr_ptr+1 around to rr_ptr, first hit wins
    always_comb begin
        gnt     = {NREQ{1'b0}};
        win_idx = {IDX_W{1'b0}};
        found_s = 1'b0;
        cand_s  = {IDX_W{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_idx = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        if (en && found_s) begin
            gnt[win_idx] = 1'b1;
        end else begin
            gnt = {NREQ{1'b0}};
        end
    end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one single-port FIFO between NREQ producers and one consumer, one op per clock.
// Define FIFO_SHARE_STATS_EN to add the saturating stall_cnt output.
module fifo_share_ctrl
    import fifo_share_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = FS_WIDTH,
    parameter  int DEPTH = FS_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       gnt,
    input  logic                  rd_req,
    output logic                  rd_ack,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  fifo_wr_en,
    output logic                  fifo_rd_en,
    output logic [WIDTH-1:0]      fifo_din,
    input  logic [WIDTH-1:0]      fifo_dout,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_SHARE_STATS_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             pri_rd_r;
    logic             pri_rd_nxt_s;
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] win_idx_s;
    logic [NREQ-1:0]  arb_gnt_s;
    logic             wr_elig_s;
    logic             rd_elig_s;
    op_t              op_s;
    logic [WIDTH-1:0] wr_data_s;
    logic [WIDTH-1:0] fifo_din_r;
    logic             fifo_wr_en_r;
    logic             fifo_rd_en_r;
    logic             rd_valid_r;

    // full blocks every grant this cycle, even when a read is also accepted
    assign wr_elig_s = (|req) && !full_r;
    assign rd_elig_s = rd_req && !empty_r;

    // One decision per cycle; the priority bit only flips on contention
    always_comb begin
        op_s         = OP_NONE;
        pri_rd_nxt_s = pri_rd_r;
        if (rd_elig_s && wr_elig_s) begin
            pri_rd_nxt_s = ~pri_rd_r;
            if (pri_rd_r) begin
                op_s = OP_RD;
            end else begin
                op_s = OP_WR;
            end
        end else if (rd_elig_s) begin
            op_s = OP_RD;
        end else if (wr_elig_s) begin
            op_s = OP_WR;
        end else begin
            op_s = OP_NONE;
        end
    end

    rr_arbiter #(
        .NREQ    (NREQ)
    ) u_arb (
        .req     (req),
        .en      (op_s == OP_WR),
        .rr_ptr  (rr_ptr_r),
        .gnt     (arb_gnt_s),
        .win_idx (win_idx_s)
    );

    // Select the winning producer's data lane
    always_comb begin
        wr_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_s == IDX_W'(i)) begin
                wr_data_s = din[i*WIDTH +: WIDTH];
            end else begin
                wr_data_s = wr_data_s;
            end
        end
    end

    // Scheduled occupancy after this cycle's decision
    always_comb begin
        case (op_s)
            OP_WR:   count_nxt_s = count_r + CNT_W'(1);
            OP_RD:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Occupancy, flags, read priority and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            pri_rd_r <= 1'b1;
            rr_ptr_r <= IDX_W'(NREQ - 1);
        end else begin
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r  <= (count_nxt_s == {CNT_W{1'b0}});
            pri_rd_r <= pri_rd_nxt_s;
            if (op_s == OP_WR) begin
                rr_ptr_r <= win_idx_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Single strobe stage keeps FIFO ops in decision order; rd_valid trails by one more
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_wr_en_r <= 1'b0;
            fifo_rd_en_r <= 1'b0;
            fifo_din_r   <= {WIDTH{1'b0}};
            rd_valid_r   <= 1'b0;
        end else begin
            fifo_wr_en_r <= (op_s == OP_WR);
            fifo_rd_en_r <= (op_s == OP_RD);
            if (op_s == OP_WR) begin
                fifo_din_r <= wr_data_s;
            end else begin
                fifo_din_r <= fifo_din_r;
            end
            rd_valid_r   <= fifo_rd_en_r;
        end
    end

    assign gnt        = arb_gnt_s;
    assign rd_ack     = (op_s == OP_RD);
    assign fifo_wr_en = fifo_wr_en_r;
    assign fifo_rd_en = fifo_rd_en_r;
    assign fifo_din   = fifo_din_r;
    assign count      = count_r;
    assign full       = full_r;
    assign empty      = empty_r;
    // FIFO output register is already the data; gate it so idle cycles read zero
    assign rd_data    = rd_valid_r ? fifo_dout : {WIDTH{1'b0}};
    assign rd_valid   = rd_valid_r;

`ifdef FIFO_SHARE_STATS_EN
    logic [15:0] stall_cnt_r;

    // Cycles with a pending producer request that received no grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 16'h0000;
        end else if ((|req) && (op_s != OP_WR)) begin
            stall_cnt_r <= sat_inc16(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: doc/fifo_share_ctrl.md
# fifo_share_ctrl

Controller that shares the single-port 8-bit × 32-entry FIFO buffer between NREQ producers and one consumer. It arbitrates producer writes round-robin and schedules reads against writes, because the FIFO performs at most one operation per clock. It tracks occupancy itself and drives the FIFO's `wr_en`/`rd_en`/`din` strobes from registers. It sits directly in front of the FIFO instance; the FIFO's own `full`/`empty` outputs are not used.

## Interface
Parameters:
- `NREQ`, default 4: number of producers (2..8).
- `WIDTH`, default 8: data width; must match the FIFO.
- `DEPTH`, default 32: FIFO capacity; must match the FIFO.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (low = reset). The top level drives the FIFO's active-high `rst` from `~rst`.
- `req`  in  NREQ  per-producer write request, level.
- `din`  in  NREQ*WIDTH  producer data; producer i uses bits [i*WIDTH +: WIDTH].
- `gnt`  out  NREQ  one-hot, combinational; `gnt[i]` high means producer i's data is accepted at this edge.
- `rd_req`  in  1  consumer read request, level.
- `rd_ack`  out  1  combinational; a read is accepted at this edge.
- `rd_data`  out  WIDTH  read data; valid only while `rd_valid` is high.
- `rd_valid`  out  1  one-cycle pulse, two cycles after `rd_ack`.
- `fifo_wr_en`, `fifo_rd_en`  out  1  registered FIFO strobes.
- `fifo_din`  out  WIDTH  registered FIFO write data.
- `fifo_dout`  in  WIDTH  FIFO output register.
- `count`  out  $clog2(DEPTH+1)  scheduled occupancy, 0..DEPTH.
- `full`, `empty`  out  1  `count == DEPTH`, `count == 0`.

## Operation
- Each cycle, exactly one decision is made: READ, WRITE or NONE.
  - READ is eligible when `rd_req && !empty`.
  - WRITE is eligible when some `req[i]` is high `&& !full`.
- Contention (both eligible): the `pri_rd` toggle bit decides.
  - `pri_rd=1` → READ wins; `pri_rd=0` → WRITE wins.
  - `pri_rd` inverts after every contended decision.
  - Uncontended decisions leave `pri_rd` unchanged.
  - Reset value of `pri_rd` is 1.
- WRITE:
  - The round-robin pointer `rr_ptr` names the lowest-priority requester of the previous winner.
  - The search starts at `rr_ptr+1` mod NREQ.
  - `rr_ptr` updates to the winner.
  - Reset value of `rr_ptr` is NREQ-1, so requester 0 wins first.
- Count update: +1 on WRITE, −1 on READ, unchanged on NONE. It never goes to both, and never overflows or underflows.
- Order preservation: both strobes come from one pipeline register stage, so the FIFO executes operations in decision order. `empty` can therefore be computed from `count` with no in-flight correction.
- Invariant: `fifo_wr_en && fifo_rd_en` is never true.
- Reset (asynchronous, mid-operation included) clears:
  - `count`, `fifo_wr_en`, `fifo_rd_en`, `fifo_din`, `rd_valid`, `rd_data`, and the read pipeline.
  - Outputs after reset: `empty`=1, `full`=0, `gnt`=0, `rd_ack`=0.
  - Any in-flight operation is discarded.

## Timing
- Decision cycle t: `gnt`/`rd_ack` are high combinationally. Producer data is sampled at the end of t.
- Cycle t+1: `fifo_wr_en`+`fifo_din` or `fifo_rd_en` is high. The FIFO acts at the end of t+1.
- Cycle t+2: `rd_data` = `fifo_dout` and `rd_valid`=1 for a READ decided at t.
- Throughput: one operation per cycle in total; reads and writes are interleaved 1:1 under sustained contention.
- A producer keeps `req` high and holds its data until it sees `gnt`. It may change its data the cycle after `gnt`.
- `full` at t blocks all grants at t, even if `rd_ack` is also high at t. The freed slot is visible at t+1.

## Configuration
- `FIFO_SHARE_STATS_EN` defined:
  - Adds output `stall_cnt` (16 bit).
  - Increments every cycle in which any `req` is high but no `gnt` is issued.
  - Saturates at 16'hFFFF; reset value is 0.
- `FIFO_SHARE_STATS_EN` undefined:
  - The port and the counter do not exist.
  - All other behaviour is identical.

## Structure
- Package `fifo_share_pkg`:
  - `WIDTH`/`DEPTH` defaults.
  - Count width constant.
  - Enum `op_t` {OP_NONE, OP_WR, OP_RD}.
- Sub-module `rr_arbiter`:
  - Parameter NREQ.
  - Inputs `req`, `en`, `rr_ptr`.
  - Outputs one-hot `gnt` and encoded winner index.
  - Purely combinational; the pointer register lives in the parent.

## Test plan
- Reset, then `req`=4'b1111 with `rd_req`=0 for 40 cycles:
  - Grants rotate 0,1,2,3,...
  - Exactly 32 grants are issued; `full`=1 and `count`=32 afterwards.
  - No `fifo_wr_en` appears while the FIFO is full.
- Fill with 8'h00..8'h1F, then hold `rd_req`=1:
  - `rd_valid` pulses return 00..1F in order, each two cycles after its `rd_ack`.
  - `empty`=1 after the 32nd ack.
- Contention at `count`=10 with `req`[2] and `rd_req` both held high:
  - Decisions go RD, WR, RD, WR, ...; `count` oscillates 10/9.
  - The strobes are never both high.
- `full` with `rd_req` and `req` high:
  - Cycle t: `rd_ack`=1, `gnt`=0.
  - Cycle t+1: write granted; `count` goes 32→31→32.
- Assert `rst` low mid-stream with `count`=5 and a read in flight:
  - Outputs clear asynchronously and no `rd_valid` appears.
  - After release, the first grant goes to requester 0.
- With `FIFO_SHARE_STATS_EN` defined: hold `req`=1 while full for 20 cycles → `stall_cnt`=20.
